frame_seq: RTL and testbench

// Frame sequencer between data_sync and the 3x3 filter core. It latches the parsed image header
// (width/height), counts accepted pixel beats, and drives the filter's line-buffer prime/run phases,

---
 rtl/frame_seq.sv | 172 +++++++++++++++++
 tb/tb_frame_seq.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/frame_seq.sv
// Frame sequencer between data_sync and the 3x3 filter core: tracks header geometry,
// walks row/col over accepted beats, drives prime/run/border phases and reports errors.
module frame_seq #(
  parameter int DIM_W       = 32,
  parameter int KERNEL      = 3,
  parameter int TIMEOUT_CYC = 1_000_000,
  parameter int FCNT_W      = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              hdr_vld,
  input  logic [DIM_W-1:0]  hdr_width,
  input  logic [DIM_W-1:0]  hdr_height,
  input  logic              pix_vld,
  output logic              pix_rdy,
  input  logic              line,
  input  logic              done,
  input  logic              filt_rdy,
  input  logic              abort,
  output logic              prime,
  output logic              filt_en,
  output logic              border,
  output logic              busy,
  output logic              frame_done,
  output logic              err_size,
  output logic              err_sync,
  output logic              err_timeout,
  output logic [FCNT_W-1:0] frame_cnt,
  output logic [2:0]        dbg_state
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    PRIME = 3'd1,
    RUN   = 3'd2,
    DONE  = 3'd3,
    ERR   = 3'd4
  } state_t;

  localparam int TMO_W = $clog2(TIMEOUT_CYC) + 1;
  localparam logic [DIM_W-1:0] ONE        = DIM_W'(1);
  localparam logic [DIM_W-1:0] KDIM       = DIM_W'(KERNEL);
  localparam logic [DIM_W-1:0] HALF       = DIM_W'(KERNEL / 2);
  localparam logic [DIM_W-1:0] PRIME_LAST = DIM_W'(KERNEL - 2);
  // The stall that makes the counter reach TIMEOUT_CYC-1 is the one that trips.
  localparam logic [TMO_W-1:0] TMO_TRIP   = TMO_W'(TIMEOUT_CYC - 2);

  state_t             state_q;
  logic [DIM_W-1:0]   w_q, h_q;
  logic [DIM_W-1:0]   col_q, row_q;
  logic [TMO_W-1:0]   tmo_q;
  logic [FCNT_W-1:0]  frame_cnt_q;
  logic               err_size_q, err_sync_q, err_timeout_q;

  logic               active;
  logic               beat;
  logic               last_col;
  logic               last_row;
  logic               end_frame;
  logic               sync_bad;
  logic               hdr_small;
  logic [DIM_W-1:0]   col_d, row_d;

  // Handshake: a beat transfers on any cycle where pix_vld and pix_rdy are both high;
  // pix_rdy depends only on the registered state, filt_rdy and abort.
  assign active  = (state_q == PRIME) || (state_q == RUN);
  assign pix_rdy = active & filt_rdy & ~abort;
  assign beat    = pix_vld & pix_rdy;

  assign last_col  = (col_q == w_q - ONE);
  assign last_row  = (row_q == h_q - ONE);
  assign end_frame = last_col & last_row;
  assign sync_bad  = (line != last_col) | (done != end_frame);
  assign hdr_small = (hdr_width < KDIM) | (hdr_height < KDIM);

  always_comb begin
    col_d = col_q + ONE;
    row_d = row_q;
    if (last_col) begin
      col_d = '0;
      row_d = row_q + ONE;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= IDLE;
      w_q           <= '0;
      h_q           <= '0;
      col_q         <= '0;
      row_q         <= '0;
      tmo_q         <= '0;
      frame_cnt_q   <= '0;
      err_size_q    <= 1'b0;
      err_sync_q    <= 1'b0;
      err_timeout_q <= 1'b0;
    end else begin
      err_size_q    <= 1'b0;
      err_sync_q    <= 1'b0;
      err_timeout_q <= 1'b0;
      if (abort) begin
        // Abort outranks any beat, header or error arriving in the same cycle.
        state_q <= IDLE;
        col_q   <= '0;
        row_q   <= '0;
        tmo_q   <= '0;
      end else begin
        case (state_q)
          IDLE: begin
            if (hdr_vld) begin
              w_q <= hdr_width;
              h_q <= hdr_height;
              if (hdr_small) begin
                err_size_q <= 1'b1;
              end else begin
                state_q <= PRIME;
                col_q   <= '0;
                row_q   <= '0;
                tmo_q   <= '0;
              end
            end
          end
          PRIME, RUN: begin
            if (beat) begin
              if (sync_bad) begin
                err_sync_q <= 1'b1;
                state_q    <= ERR;
              end else begin
                col_q <= col_d;
                row_q <= row_d;
                tmo_q <= '0;
                if (state_q == PRIME && last_col && row_q == PRIME_LAST) begin
                  state_q <= RUN;
                end
                if (state_q == RUN && end_frame) begin
                  state_q     <= DONE;
                  frame_cnt_q <= frame_cnt_q + FCNT_W'(1);
                end
              end
            end else if (tmo_q == TMO_TRIP) begin
              err_timeout_q <= 1'b1;
              state_q       <= ERR;
            end else begin
              tmo_q <= tmo_q + TMO_W'(1);
            end
          end
          DONE: begin
            state_q <= IDLE;
          end
          ERR: begin
            state_q <= ERR;
          end
          default: begin
            state_q <= IDLE;
          end
        endcase
      end
    end
  end

  assign prime       = (state_q == PRIME);
  assign filt_en     = (state_q == RUN);
  assign busy        = active;
  assign frame_done  = (state_q == DONE);
  assign border      = (state_q == RUN) & ((col_q < HALF) | (col_q >= w_q - HALF));
  assign err_size    = err_size_q;
  assign err_sync    = err_sync_q;
  assign err_timeout = err_timeout_q;
  assign frame_cnt   = frame_cnt_q;
  assign dbg_state   = state_q;

endmodule

// File: tb/tb_frame_seq.sv
// Directed bench for frame_seq: beat-flag scoreboard, header/sync/timeout/abort scenarios.
module tb_frame_seq;

  localparam int DIM_W  = 32;
  localparam int KERNEL = 3;
  localparam int FCNT_W = 16;

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_PRIME = 3'd1;
  localparam logic [2:0] S_DONE  = 3'd3;
  localparam logic [2:0] S_ERR   = 3'd4;

  logic              clk = 1'b0;
  logic              rst;
  logic              hdr_vld;
  logic [DIM_W-1:0]  hdr_width, hdr_height;
  logic              pix_vld, line, done, filt_rdy, abort;

  logic              pix_rdy, prime, filt_en, border, busy, frame_done;
  logic              err_size, err_sync, err_timeout;
  logic [FCNT_W-1:0] frame_cnt;
  logic [2:0]        dbg_state;

  logic              to_pix_rdy, to_prime, to_filt_en, to_border, to_busy, to_frame_done;
  logic              to_err_size, to_err_sync, to_err_timeout;
  logic [FCNT_W-1:0] to_frame_cnt;
  logic [2:0]        to_dbg_state;

  int checks = 0;
  int errors = 0;
  int exp_frames = 0;
  logic [2:0] exp_q[$];

  frame_seq #(.DIM_W(DIM_W), .KERNEL(KERNEL), .TIMEOUT_CYC(1_000_000), .FCNT_W(FCNT_W)) u_dut (
    .clk(clk), .rst(rst), .hdr_vld(hdr_vld), .hdr_width(hdr_width), .hdr_height(hdr_height),
    .pix_vld(pix_vld), .pix_rdy(pix_rdy), .line(line), .done(done), .filt_rdy(filt_rdy),
    .abort(abort), .prime(prime), .filt_en(filt_en), .border(border), .busy(busy),
    .frame_done(frame_done), .err_size(err_size), .err_sync(err_sync),
    .err_timeout(err_timeout), .frame_cnt(frame_cnt), .dbg_state(dbg_state)
  );

  // Short-timeout copy sharing the same inputs, used for the stall scenario.
  frame_seq #(.DIM_W(DIM_W), .KERNEL(KERNEL), .TIMEOUT_CYC(50), .FCNT_W(FCNT_W)) u_to (
    .clk(clk), .rst(rst), .hdr_vld(hdr_vld), .hdr_width(hdr_width), .hdr_height(hdr_height),
    .pix_vld(pix_vld), .pix_rdy(to_pix_rdy), .line(line), .done(done), .filt_rdy(filt_rdy),
    .abort(abort), .prime(to_prime), .filt_en(to_filt_en), .border(to_border), .busy(to_busy),
    .frame_done(to_frame_done), .err_size(to_err_size), .err_sync(to_err_sync),
    .err_timeout(to_err_timeout), .frame_cnt(to_frame_cnt), .dbg_state(to_dbg_state)
  );

  always #5 clk = ~clk;

  initial begin
    #900_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Scoreboard: each accepted beat must match the flags queued when it was driven.
  always @(negedge clk) begin
    if (!rst && pix_vld && pix_rdy) begin
      chk("beat_expected", exp_q.size() > 0, 1);
      if (exp_q.size() > 0) chk("beat_flags", {prime, filt_en, border}, exp_q.pop_front());
    end
  end

  task automatic send_hdr(input int w, input int h);
    hdr_vld    = 1'b1;
    hdr_width  = DIM_W'(w);
    hdr_height = DIM_W'(h);
    tick();
    hdr_vld = 1'b0;
  endtask

  task automatic pulse_abort();
    abort = 1'b1;
    tick();
    abort = 1'b0;
  endtask

  task automatic send_beat(input logic l, input logic d, input bit rnd);
    int n;
    bit acc;
    pix_vld = 1'b1;
    line    = l;
    done    = d;
    acc     = 1'b0;
    n       = 0;
    while (!acc && n < 200) begin
      if (rnd) filt_rdy = 1'($urandom_range(0, 1));
      #1;
      acc = pix_rdy;
      if (rnd) chk("pix_rdy_follows", pix_rdy, filt_rdy);
      @(posedge clk);
      #1;
      n++;
    end
    pix_vld  = 1'b0;
    line     = 1'b0;
    done     = 1'b0;
    filt_rdy = 1'b1;
    chk("beat_accept_bound", acc, 1);
  endtask

  task automatic run_frame(input int w, input int h, input int n, input int gmax,
                           input bit rnd, input int bad_idx);
    for (int i = 0; i < n; i++) begin
      int col;
      int row;
      logic p, b;
      col = i % w;
      row = i / w;
      repeat ($urandom_range(0, gmax)) tick();
      p = (row <= KERNEL - 2);
      b = !p && ((col < KERNEL / 2) || (col >= w - KERNEL / 2));
      exp_q.push_back({p, !p, b});
      send_beat((col == w - 1) ^ (i == bad_idx), i == w * h - 1, rnd);
    end
    if (n == w * h) begin
      exp_frames++;
      chk("frame_done_pulse", frame_done, 1);
      chk("frame_cnt", frame_cnt, exp_frames);
      chk("done_state", dbg_state, S_DONE);
      tick();
      chk("frame_done_clear", frame_done, 0);
      chk("idle_after_done", dbg_state, S_IDLE);
      chk("busy_after_done", busy, 0);
    end
  endtask

  initial begin
    int n;
    rst = 1'b1; hdr_vld = 1'b0; hdr_width = '0; hdr_height = '0;
    pix_vld = 1'b0; line = 1'b0; done = 1'b0; filt_rdy = 1'b1; abort = 1'b0;
    repeat (3) tick();
    rst = 1'b0;

    chk("rst_state", dbg_state, S_IDLE);
    chk("rst_pix_rdy", pix_rdy, 0);
    chk("rst_outputs", {prime, filt_en, border, busy, frame_done}, 0);
    chk("rst_errors", {err_size, err_sync, err_timeout}, 0);
    chk("rst_frame_cnt", frame_cnt, 0);

    // 7x7 frame with long random gaps between beats.
    send_hdr(7, 7);
    chk("hdr_ok_no_err", err_size, 0);
    chk("hdr_ok_prime", dbg_state, S_PRIME);
    chk("hdr_ok_busy", busy, 1);
    run_frame(7, 7, 49, 100, 0, -1);

    // Undersized header rejected, then a minimal 3x3 frame.
    send_hdr(2, 7);
    chk("err_size_pulse", err_size, 1);
    chk("err_size_idle", dbg_state, S_IDLE);
    pix_vld = 1'b1;
    #1;
    chk("err_size_no_rdy", pix_rdy, 0);
    pix_vld = 1'b0;
    tick();
    chk("err_size_clear", err_size, 0);
    send_hdr(3, 3);
    chk("hdr3_prime", dbg_state, S_PRIME);
    run_frame(3, 3, 9, 3, 0, -1);

    // filt_rdy toggled randomly throughout a 7x7 frame.
    send_hdr(7, 7);
    run_frame(7, 7, 49, 2, 1, -1);

    // Wrong line marker on beat 5.
    send_hdr(7, 7);
    run_frame(7, 7, 6, 0, 0, 5);
    chk("err_sync_pulse", err_sync, 1);
    chk("err_sync_no_tmo", err_timeout, 0);
    chk("err_sync_state", dbg_state, S_ERR);
    pix_vld = 1'b1;
    #1;
    chk("err_no_rdy", pix_rdy, 0);
    tick();
    pix_vld = 1'b0;
    chk("err_sync_clear", err_sync, 0);
    chk("err_held", dbg_state, S_ERR);
    pulse_abort();
    chk("err_abort_idle", dbg_state, S_IDLE);

    // Abort colliding with a beat at row 3.
    send_hdr(7, 7);
    run_frame(7, 7, 21, 0, 0, -1);
    pix_vld = 1'b1;
    abort   = 1'b1;
    #1;
    chk("abort_blocks_rdy", pix_rdy, 0);
    tick();
    abort   = 1'b0;
    pix_vld = 1'b0;
    chk("abort_idle", dbg_state, S_IDLE);
    chk("abort_no_done", frame_done, 0);
    chk("abort_cnt_kept", frame_cnt, exp_frames);
    send_hdr(3, 3);
    run_frame(3, 3, 9, 0, 0, -1);

    // Stall mid-RUN on the short-timeout instance.
    pulse_abort();
    chk("to_idle", to_dbg_state, S_IDLE);
    send_hdr(7, 7);
    run_frame(7, 7, 20, 0, 0, -1);
    n = 0;
    while (n < 100) begin
      tick();
      n++;
      if (to_err_timeout) break;
    end
    chk("timeout_latency", n, 49);
    chk("timeout_state", to_dbg_state, S_ERR);
    chk("timeout_no_rdy", to_pix_rdy, 0);
    chk("main_no_timeout", err_timeout, 0);
    pulse_abort();
    chk("timeout_abort_idle", to_dbg_state, S_IDLE);

    chk("scoreboard_drained", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
